// File: rtl/seg_pkg.sv
// Seven-segment pattern constants and frame-state type shared by the encoder
// and decoder sides of the multiplexed display path.
package seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } frame_state_t;

    // True when exactly one active-low digit select is asserted
    function automatic logic an_eligible(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_eligible = 1'b1;
            default:                            an_eligible = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] an_slot(input logic [3:0] an);
        case (an)
            4'b1101: an_slot = 2'd1;
            4'b1011: an_slot = 2'd2;
            4'b0111: an_slot = 2'd3;
            default: an_slot = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_valid,
    output logic       o_blank
);

    always_comb begin
        o_nibble = '0;
        o_valid  = 1'b1;
        o_blank  = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: begin
                o_valid = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Snoops a multiplexed 4-digit seven-segment bus, debounces each digit and
// publishes complete frames as a 16-bit hex word.
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] hex_out,
    output logic        frame_valid,
    output logic        bad_seg,
    output logic [7:0]  bad_cnt
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    logic [3:0]   r_an;
    logic [6:0]   r_seg;
    logic [7:0]   r_cnt;
    logic [15:0]  r_shadow;
    logic [3:0]   r_mask;
    logic [15:0]  r_hex;
    logic         r_bad_seg;
    logic [7:0]   r_bad_cnt;
    frame_state_t r_state;

    frame_state_t w_state_next;
    logic         w_eligible;
    logic         w_same;
    logic         w_capture;
    logic         w_good_cap;
    logic         w_bad_cap;
    logic [1:0]   w_slot;
    logic [3:0]   w_slot_bit;
    logic [3:0]   w_nibble;
    logic         w_valid;
    logic         w_blank;
    logic [15:0]  w_shadow_next;
    logic [3:0]   w_mask_next;

    seg_to_hex u_dec (
        .i_seg    (seg_in),
        .o_nibble (w_nibble),
        .o_valid  (w_valid),
        .o_blank  (w_blank)
    );

    assign w_eligible = an_eligible(an_in);
    assign w_same     = (an_in == r_an) && (seg_in == r_seg);
    assign w_slot     = an_slot(an_in);
    assign w_slot_bit = 4'b0001 << w_slot;

    // Fires only on the edge the counter climbs from STABLE-1 to STABLE
    assign w_capture  = w_eligible && w_same && (r_cnt == LP_STABLE - 8'd1);
    assign w_good_cap = w_capture && w_valid;
    assign w_bad_cap  = w_capture && !w_valid && !w_blank;

    always_comb begin
        w_shadow_next = r_shadow;
        if (w_good_cap) begin
            w_shadow_next[{w_slot, 2'b00} +: 4] = w_nibble;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_good_cap) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_good_cap && ((r_mask | w_slot_bit) == 4'hF)) w_state_next = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                w_state_next = w_good_cap ? ST_COLLECT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Mask is zero throughout PUBLISH, so a capture there starts a fresh frame
    always_comb begin
        w_mask_next = r_mask;
        if (w_state_next == ST_PUBLISH) begin
            w_mask_next = '0;
        end else if (w_good_cap) begin
            w_mask_next = r_mask | w_slot_bit;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_an      <= '1;
            r_seg     <= '1;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_mask    <= '0;
            r_hex     <= '0;
            r_bad_seg <= 1'b0;
            r_bad_cnt <= '0;
            r_state   <= ST_IDLE;
        end else begin
            r_an      <= an_in;
            r_seg     <= seg_in;
            r_shadow  <= w_shadow_next;
            r_mask    <= w_mask_next;
            r_state   <= w_state_next;
            r_bad_seg <= w_bad_cap;

            if (!w_eligible) begin
                r_cnt <= '0;
            end else if (!w_same) begin
                r_cnt <= 8'd1;
            end else if (r_cnt != LP_STABLE) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_bad_cap && (r_bad_cnt != 8'hFF)) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end

            // Output word is loaded on the completing edge so it is visible
            // during the PUBLISH cycle alongside frame_valid
            if ((r_state == ST_COLLECT) && (w_state_next == ST_PUBLISH)) begin
                r_hex <= w_shadow_next;
            end
        end
    end

    assign hex_out     = r_hex;
    assign frame_valid = (r_state == ST_PUBLISH);
    assign bad_seg     = r_bad_seg;
    assign bad_cnt     = r_bad_cnt;

endmodule
